// File: rtl/bram_portb_arbiter.sv
// BRAM port B arbiter: VGA scan-out has absolute priority, aux engine
// gets the port only while VGA is idle, with a starvation timeout flag.
module bram_portb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  vga_active,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_rdata,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    input  logic [DATA_WIDTH-1:0] aux_wdata,
    output logic                  aux_ack,
    output logic [DATA_WIDTH-1:0] aux_rdata,
    output logic                  aux_busy,
    output logic                  aux_timeout,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_ack;
    logic                  r_timeout;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CW-1:0]         r_wait_cnt;
    logic                  w_own;
    logic                  w_wr_done;
    logic                  w_wait_inc;
    logic                  w_wait_clr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (aux_req && !vga_active) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (vga_active || aux_we) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Reset gates ownership so a write pending in ISSUE never reaches the BRAM.
    always_comb begin
        w_own     = (r_state == S_ISSUE) && !vga_active && !reset;
        mem_addr  = w_own ? aux_addr : vga_addr;
        mem_we    = w_own && aux_we;
        mem_wdata = aux_wdata;
        aux_busy  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    end

    assign w_wr_done  = (r_state == S_ISSUE) && !vga_active && aux_we;
    assign w_wait_clr = r_ack || !aux_req;
    assign w_wait_inc = aux_req && vga_active && (r_state == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_ack     <= w_wr_done || (r_state == S_WAIT);
            r_timeout <= 1'b0;
            if (r_state == S_WAIT) begin
                r_rdata <= mem_q;
            end
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc && r_wait_cnt != LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                r_timeout  <= (r_wait_cnt == LAST);
            end
        end
    end

    assign vga_rdata   = mem_q;
    assign aux_ack     = r_ack;
    assign aux_rdata   = r_rdata;
    assign aux_timeout = r_timeout;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Bench for bram_portb_arbiter: BRAM model, per-cycle rule checker and
// directed scenarios for priority, latency, preemption, timeout and reset.
module tb_bram_portb_arbiter;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vga_active = 1'b1;
    logic [AW-1:0] vga_addr = 16'h0100;
    logic [DW-1:0] vga_rdata;
    logic          aux_req = 1'b0;
    logic          aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic          aux_ack;
    logic [DW-1:0] aux_rdata;
    logic          aux_busy;
    logic          aux_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;

    logic [DW-1:0] bram    [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit started = 1'b0;

    logic          cur_we = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;

    int we_cnt = 0, last_we_cyc = -1;
    int ack_cnt = 0, last_ack_cyc = -1;
    int to_cnt = 0, last_to_cyc = -1;

    bram_portb_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .vga_active(vga_active),
        .vga_addr(vga_addr),
        .vga_rdata(vga_rdata),
        .aux_req(aux_req),
        .aux_we(aux_we),
        .aux_addr(aux_addr),
        .aux_wdata(aux_wdata),
        .aux_ack(aux_ack),
        .aux_rdata(aux_rdata),
        .aux_busy(aux_busy),
        .aux_timeout(aux_timeout),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous read-first BRAM, one cycle of read latency.
    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = '0;
        bram[16'h0100] = 16'h1234;
        forever begin
            @(posedge clock);
            mem_q <= bram[mem_addr];
            if (mem_we) bram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rule checker: outputs of each cycle against the arbitration rules.
    initial begin
        int            m_wait;
        logic          m_to;
        logic [DW-1:0] m_rdata;
        m_wait  = 0;
        m_to    = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        ref_mem[16'h0100] = 16'h1234;
        forever begin
            @(negedge clock);
            if (started) begin
                chk("vga_rdata_pass", vga_rdata, mem_q);
                chk("mem_wdata_pass", mem_wdata, aux_wdata);
                if (vga_active || reset) begin
                    chk("vga_prio_addr", mem_addr, vga_addr);
                    chk("vga_prio_we", mem_we, 1'b0);
                end
                if (mem_we) begin
                    we_cnt++;
                    last_we_cyc = cyc;
                    chk("wr_addr", mem_addr, cur_addr);
                    chk("wr_is_write", cur_we, 1'b1);
                end
                chk("timeout", aux_timeout, m_to);
                if (aux_timeout) begin
                    to_cnt++;
                    last_to_cyc = cyc;
                end
                if (aux_ack) begin
                    ack_cnt++;
                    last_ack_cyc = cyc;
                    if (cur_we) ref_mem[cur_addr] = cur_wdata;
                    else m_rdata = ref_mem[cur_addr];
                end
                chk("aux_rdata", aux_rdata, m_rdata);
                if (reset) begin
                    m_wait  = 0;
                    m_to    = 1'b0;
                    m_rdata = '0;
                end else begin
                    m_to = 1'b0;
                    if (!aux_req || aux_ack) begin
                        m_wait = 0;
                    end else if (vga_active && !aux_busy && m_wait < TO) begin
                        m_wait++;
                        m_to = (m_wait == TO);
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int t);
        @(posedge clock);
        #1;
        cur_we    = we;
        cur_addr  = addr;
        cur_wdata = wdata;
        aux_we    = we;
        aux_addr  = addr;
        aux_wdata = wdata;
        aux_req   = 1'b1;
        t = cyc;
    endtask

    task automatic wait_ack(input int budget, output int ack_cyc);
        ack_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (aux_ack) begin
                ack_cyc = cyc;
                aux_req = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL ack_wait: no ack within %0d cycles, want ack", budget);
        aux_req = 1'b0;
    endtask

    task automatic tick;
        @(negedge clock);
        #1;
    endtask

    initial begin
        int t, a, w0, k0;
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, a, w0, k0;
        // 1: reset, then VGA owns the port while aux requests
        @(posedge clock);
        #1;
        started = 1'b1;
        tick();
        chk("rst_ack", aux_ack, 1'b0);
        chk("rst_rdata", aux_rdata, 16'h0000);
        chk("rst_timeout", aux_timeout, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        k0 = ack_cnt;
        issue(1'b0, 16'h2000, 16'h0000, t);
        repeat (5) tick();
        chk("t1_addr", mem_addr, 16'h0100);
        chk("t1_we", mem_we, 1'b0);
        chk("t1_vga_rdata", vga_rdata, 16'h1234);
        chk("t1_busy", aux_busy, 1'b0);
        chk("t1_no_ack", ack_cnt - k0, 0);
        aux_req = 1'b0;

        // 2: free-port write then read back
        @(posedge clock);
        #1;
        vga_active = 1'b0;
        w0 = we_cnt;
        issue(1'b1, 16'h2000, 16'hBEEF, t);
        wait_ack(10, a);
        chk("t2_wr_lat", a - t, 2);
        chk("t2_we_pulses", we_cnt - w0, 1);
        chk("t2_we_cyc", last_we_cyc - t, 1);
        chk("t2_bram", bram[16'h2000], 16'hBEEF);
        issue(1'b0, 16'h2000, 16'h0000, t);
        wait_ack(10, a);
        chk("t2_rd_lat", a - t, 3);
        chk("t2_rd_data", aux_rdata, 16'hBEEF);

        // 3: VGA preempts the ISSUE cycle; request retries later
        issue(1'b0, 16'h2000, 16'h0000, t);
        @(posedge clock);
        #1;
        vga_active = 1'b1;
        k0 = ack_cnt;
        tick();
        chk("t3_busy", aux_busy, 1'b1);
        chk("t3_addr", mem_addr, 16'h0100);
        chk("t3_we", mem_we, 1'b0);
        repeat (3) tick();
        chk("t3_no_ack", ack_cnt - k0, 0);
        @(posedge clock);
        #1;
        vga_active = 1'b0;
        wait_ack(10, a);
        chk("t3_rd_data", aux_rdata, 16'hBEEF);

        // 4: VGA returns during WAIT; the read still completes
        issue(1'b1, 16'h2001, 16'h5A5A, t);
        wait_ack(10, a);
        issue(1'b0, 16'h2001, 16'h0000, t);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        vga_active = 1'b1;
        tick();
        chk("t4_busy", aux_busy, 1'b1);
        chk("t4_addr", mem_addr, 16'h0100);
        tick();
        chk("t4_ack", aux_ack, 1'b1);
        chk("t4_rd_data", aux_rdata, 16'h5A5A);
        chk("t4_lat", cyc - t, 3);
        aux_req = 1'b0;

        // 5: starvation timeout with TIMEOUT=8
        k0 = to_cnt;
        w0 = ack_cnt;
        issue(1'b0, 16'h2000, 16'h0000, t);
        repeat (20) tick();
        chk("t5_pulses", to_cnt - k0, 1);
        chk("t5_pulse_cyc", last_to_cyc - t, 8);
        chk("t5_no_ack", ack_cnt - w0, 0);
        @(posedge clock);
        #1;
        aux_req = 1'b0;
        vga_active = 1'b0;

        // 6: reset while a write sits in ISSUE
        k0 = ack_cnt;
        w0 = we_cnt;
        issue(1'b1, 16'h3000, 16'hDEAD, t);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        chk("t6_we", mem_we, 1'b0);
        chk("t6_addr", mem_addr, 16'h0100);
        @(posedge clock);
        #1;
        reset = 1'b0;
        aux_req = 1'b0;
        tick();
        chk("t6_idle", aux_busy, 1'b0);
        chk("t6_rdata", aux_rdata, 16'h0000);
        repeat (3) tick();
        chk("t6_no_ack", ack_cnt - k0, 0);
        chk("t6_no_write", we_cnt - w0, 0);
        chk("t6_bram", bram[16'h3000], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
